// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator/capture blocks: state encoding and
// default counter width / stuck-line timeout.
package pwm_pkg;

    localparam int          PWM_CNT_W       = 32;
    localparam int unsigned PWM_TIMEOUT_DEF = 50_000_000;

    localparam logic [1:0] PWM_ST_IDLE = 2'd0;
    localparam logic [1:0] PWM_ST_ARM  = 2'd1;
    localparam logic [1:0] PWM_ST_RUN  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = PWM_ST_IDLE,
        ST_ARM  = PWM_ST_ARM,
        ST_RUN  = PWM_ST_RUN
    } pwm_state_e;

endpackage

// File: rtl/pwm_capture_if.sv
// Control and measurement signals of pwm_capture; master is the capture block,
// slave is the consumer that drives enable/pwm_in and reads the results.
interface pwm_capture_if
    import pwm_pkg::*;
#(
    parameter int W = PWM_CNT_W
);
    logic         enable;
    logic         pwm_in;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         meas_valid;
    logic         timeout;
    logic         level;

    modport master (
        input  enable, pwm_in,
        output period, high_time, meas_valid, timeout, level
    );

    modport slave (
        output enable, pwm_in,
        input  period, high_time, meas_valid, timeout, level
    );
endinterface

// File: rtl/pwm_in_conditioner.sv
// Metastability synchronizer for the asynchronous PWM pin, followed by an
// optional glitch filter compiled in with PWM_CAPTURE_FILTER_EN.
module pwm_in_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic s
);

    if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_bad_cfg
        $error("pwm_in_conditioner: SYNC_STAGES must be >= 2 and FILT_LEN >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;

    // NOTE: flops use non-blocking assignments so every stage samples the old value of the previous one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
    end

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int FW = $clog2(FILT_LEN + 1);

    logic          sync_out;
    logic          s_q;
    logic [FW-1:0] agree_cnt;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // s follows the input only once FILT_LEN consecutive samples disagree with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q       <= 1'b0;
            agree_cnt <= '0;
        end else if (sync_out == s_q) begin
            agree_cnt <= '0;
        end else if (agree_cnt == FW'(FILT_LEN - 1)) begin
            s_q       <= sync_out;
            agree_cnt <= '0;
        end else begin
            agree_cnt <= agree_cnt + 1'b1;
        end
    end

    assign s = s_q;
`else
    assign s = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: measures period and high time in clk cycles and flags a stuck
// line via timeout. Glitch filter selected by PWM_CAPTURE_FILTER_EN.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int          W           = PWM_CNT_W,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = PWM_TIMEOUT_DEF,
    parameter int          FILT_LEN    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pwm_capture_if.master        bus
);

    logic         s;
    logic         s_d;
    logic         rise;
    logic         fall;
    logic [W-1:0] cnt;
    logic [W-1:0] hi_cap;
    logic         cnt_expired;
    logic         do_capture;
    logic         do_fall;
    logic         do_timeout;

    pwm_state_e state_q, state_d;

    pwm_in_conditioner #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_cond (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (bus.pwm_in),
        .s      (s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s_d <= 1'b0;
        else        s_d <= s;
    end

    assign rise        = s & ~s_d;
    assign fall        = ~s & s_d;
    assign cnt_expired = (cnt == W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        do_capture = 1'b0;
        do_fall    = 1'b0;
        do_timeout = 1'b0;
        unique case (state_q)
            ST_IDLE: state_d = ST_ARM;
            ST_ARM:  if (rise) state_d = ST_RUN;
            ST_RUN: begin
                do_capture = rise;
                do_fall    = fall;
                // A rise in the expiry cycle wins over the timeout.
                if (!rise && cnt_expired) begin
                    do_timeout = 1'b1;
                    state_d    = ST_ARM;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!bus.enable) begin
            state_d    = ST_IDLE;
            do_capture = 1'b0;
            do_fall    = 1'b0;
            do_timeout = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= '0;
            hi_cap         <= '0;
            bus.period     <= '0;
            bus.high_time  <= '0;
            bus.meas_valid <= 1'b0;
            bus.timeout    <= 1'b0;
            bus.level      <= 1'b0;
        end else begin
            bus.meas_valid <= do_capture;

            if (state_d == ST_IDLE || do_timeout) begin
                cnt <= '0;
            end else if (rise) begin
                cnt <= W'(1);
            end else if (state_q == ST_RUN && cnt != W'(TIMEOUT)) begin
                cnt <= cnt + 1'b1;
            end

            if (do_fall) hi_cap <= cnt;

            if (!bus.enable) begin
                bus.timeout <= 1'b0;
            end else if (do_capture) begin
                bus.period    <= cnt;
                bus.high_time <= hi_cap;
                bus.timeout   <= 1'b0;
            end else if (do_timeout) begin
                bus.timeout <= 1'b1;
                bus.level   <= s;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed self-checking bench for pwm_capture (TIMEOUT=1000); expectations
// follow the PWM_CAPTURE_FILTER_EN build of the design.
module tb_pwm_capture;
    import pwm_pkg::*;

    localparam int W    = 32;
    localparam int SYNC = 2;
    localparam int TO   = 1000;
    localparam int FL   = 4;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam int LAT  = SYNC + 1 + FL;
`else
    localparam int LAT  = SYNC + 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_capture_if #(.W(W)) bus ();

    pwm_capture #(
        .W           (W),
        .SYNC_STAGES (SYNC),
        .TIMEOUT     (TO),
        .FILT_LEN    (FL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;
    longint rise_cyc = 0;
    longint to_cyc   = 0;
    bit     to_seen  = 1'b0;
    bit     to_prev  = 1'b0;

    logic [W-1:0] q_p[$];
    logic [W-1:0] q_h[$];
    logic         q_t[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe and timeout-edge recorder, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.meas_valid === 1'b1) begin
            q_p.push_back(bus.period);
            q_h.push_back(bus.high_time);
            q_t.push_back(bus.timeout);
        end
        if (bus.timeout === 1'b1 && !to_prev) begin
            to_cyc  = cyc;
            to_seen = 1'b1;
        end
        to_prev = (bus.timeout === 1'b1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One input period of p cycles, high for the first h; optional low glitch
    // at [g0,g1) and enable dropped at [d0,d1).
    task automatic pwm_period(input int p, input int h, input int g0, input int g1,
                              input int d0, input int d1);
        for (int i = 0; i < p; i++) begin
            @(posedge clk);
            #1;
            bus.pwm_in = (i < h) && !(i >= g0 && i < g1);
            bus.enable = !(i >= d0 && i < d1);
            if (i == 0) rise_cyc = cyc;
        end
    endtask

    task automatic clean(input int p, input int h, input int n);
        for (int k = 0; k < n; k++) pwm_period(p, h, -1, -1, -1, -1);
    endtask

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            bus.pwm_in = v;
        end
    endtask

    task automatic clear_q();
        q_p.delete();
        q_h.delete();
        q_t.delete();
    endtask

    task automatic wait_timeout(input string tag);
        for (int i = 0; i < 3 * TO; i++) begin
            if (to_seen) break;
            @(posedge clk);
            #1;
        end
        check({tag, "_seen"}, 64'(to_seen), 64'd1);
        check({tag, "_delay"}, 64'(to_cyc - rise_cyc), 64'(LAT + TO - 1));
    endtask

    task automatic check_q(input string tag, input int idx, input int p, input int h);
        logic [W-1:0] gp, gh;
        gp = (idx < q_p.size()) ? q_p[idx] : '1;
        gh = (idx < q_h.size()) ? q_h[idx] : '1;
        check($sformatf("%s_period%0d", tag, idx), 64'(gp), 64'(p));
        check($sformatf("%s_high%0d", tag, idx), 64'(gh), 64'(h));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.enable = 1'b1;
        bus.pwm_in = 1'b0;

        // Reset with the input toggling.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.pwm_in = ~bus.pwm_in;
            check("rst_meas", {bus.period, bus.high_time}, 64'd0);
            check("rst_flags", 64'({bus.meas_valid, bus.timeout, bus.level}), 64'd0);
        end
        bus.pwm_in = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_meas", {bus.period, bus.high_time}, 64'd0);
        check("post_rst_flags", 64'({bus.meas_valid, bus.timeout, bus.level}), 64'd0);
        hold(1'b0, 10);

        // Steady 100/30: 5 rises give 4 strobes; then held low until timeout.
        clear_q();
        to_seen = 1'b0;
        clean(100, 30, 5);
        wait_timeout("to_low");
        check("steady_count", 64'(q_p.size()), 64'd4);
        for (int i = 0; i < 4; i++) check_q("steady", i, 100, 30);
        check("to_low_level", 64'(bus.level), 64'd0);
        check("to_low_period_hold", 64'(bus.period), 64'd100);
        check("to_low_high_hold", 64'(bus.high_time), 64'd30);

        // Resume: first rise only re-arms, second clears timeout with a result.
        clear_q();
        to_seen = 1'b0;
        clean(100, 30, 1);
        check("resume_to_still_set", 64'(bus.timeout), 64'd1);
        check("resume_no_strobe", 64'(q_p.size()), 64'd0);
        clean(100, 30, 1);
        @(posedge clk);
        #1;
        bus.pwm_in = 1'b1;
        rise_cyc   = cyc;
        wait_timeout("to_high");
        check("resume_count", 64'(q_p.size()), 64'd2);
        check("resume_to_cleared", 64'((q_t.size() > 0) ? q_t[0] : 1'b1), 64'd0);
        for (int i = 0; i < 2; i++) check_q("resume", i, 100, 30);
        check("to_high_level", 64'(bus.level), 64'd1);
        check("to_high_period_hold", 64'(bus.period), 64'd100);

        // Enable dropped at cycle 50 of the fourth period.
        clear_q();
        hold(1'b0, 20);
        clean(100, 30, 3);
        pwm_period(100, 30, -1, -1, 50, 60);
        check("dis_count", 64'(q_p.size()), 64'd3);
        check("dis_timeout", 64'(bus.timeout), 64'd0);
        check("dis_period_hold", 64'(bus.period), 64'd100);
        clean(100, 30, 1);
        check("dis_no_strobe", 64'(q_p.size()), 64'd3);
        clean(100, 30, 2);
        check("dis_restart_count", 64'(q_p.size()), 64'd5);
        for (int i = 0; i < 5; i++) check_q("dis", i, 100, 30);

        // Two-cycle low glitch inside the high phase.
        clear_q();
        clean(100, 30, 1);
        pwm_period(100, 30, 10, 12, -1, -1);
        clean(100, 30, 2);
`ifdef PWM_CAPTURE_FILTER_EN
        check("glitch_count", 64'(q_p.size()), 64'd4);
        for (int i = 0; i < 4; i++) check_q("glitch", i, 100, 30);
`else
        check("glitch_count", 64'(q_p.size()), 64'd5);
        check_q("glitch", 0, 100, 30);
        check_q("glitch", 1, 100, 30);
        check_q("glitch", 2, 12, 10);
        check_q("glitch", 3, 88, 18);
        check_q("glitch", 4, 100, 30);
`endif

        // Period change 100 -> 250.
        clear_q();
        clean(250, 80, 2);
        clean(100, 30, 1);
        check("chg_count", 64'(q_p.size()), 64'd3);
        check_q("chg", 0, 100, 30);
        check_q("chg", 1, 250, 80);
        check_q("chg", 2, 250, 80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform and reports its period and high time in `clk` cycles. It is the receive-side counterpart of the team's `pwm` generator. Typical uses are loopback-checking the buzzer drive and decoding PWM from external sensors or controllers. It sits between a board input pin and any register or control logic, and flags a stuck line (0 % or 100 % duty) through a timeout.

## Interface
- `W`, 32: width of the cycle counter and of the measurement outputs.
- `SYNC_STAGES`, 2: number of flops in the metastability synchronizer (minimum 2).
- `TIMEOUT`, 50_000_000: cycles without a rising edge before a stuck line is declared (1 s at 50 MHz); must be < 2^W.
- `FILT_LEN`, 4: length of the glitch filter, in consecutive samples; used only when the filter is compiled in.

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `enable`, input, 1: when high, measurement runs; when low, the block is held idle.
- `pwm_in`, input, 1: asynchronous PWM input.
- `period`, output, W: last measured period, in cycles between rising edges.
- `high_time`, output, W: last measured high time, in cycles.
- `meas_valid`, output, 1: one-cycle strobe; `period` and `high_time` are updated in the same cycle.
- `timeout`, output, 1: level; high means no rising edge for `TIMEOUT` cycles.
- `level`, output, 1: the conditioned input level, latched when the timeout fires.

## Operation
- Conditioning: `pwm_in` passes through a `SYNC_STAGES` synchronizer, then the optional filter, to produce `s`. The register `s_d` holds `s` from the previous cycle.
  - `rise` = `s & ~s_d`; `fall` = `~s & s_d`.
- States:
  - IDLE: entered on reset or when `enable`=0. `cnt`=0.
  - ARM: waiting for the first rising edge.
  - RUN: measuring.
- State transitions:
  - IDLE → ARM when `enable`=1.
  - ARM → RUN on `rise`, with `cnt`<=1. A `fall` in ARM is ignored.
- Counter behaviour in RUN:
  - On `rise`: `cnt`<=1.
  - Otherwise: `cnt`<=`cnt`+1, saturating at `TIMEOUT`.
- Capture in RUN:
  - On `fall`: `hi_cap`<=`cnt`.
  - On `rise`: `period`<=`cnt`, `high_time`<=`hi_cap`, `meas_valid`<=1, `timeout`<=0.
  - For a steady input with H high cycles per P-cycle period, this yields `period`=P and `high_time`=H.
- First valid result: the first `rise` only starts counting. The first `meas_valid` comes on the second `rise`.
- Timeout: if `cnt`==`TIMEOUT`-1 and there is no `rise`:
  - `timeout`<=1 and `level`<=`s`.
  - State → ARM.
  - `period` and `high_time` hold their last values.
- Simultaneous timeout and `rise`: the `rise` wins (normal capture, no timeout).
- `enable` falling mid-measurement:
  - Next cycle is IDLE; the partial measurement is discarded and no strobe is issued.
  - `timeout` is cleared; `period`, `high_time` and `level` hold.
- Reset values: `period`=0, `high_time`=0, `meas_valid`=0, `timeout`=0, `level`=0. The synchronizer flops, `s_d`, `cnt` and `hi_cap` also reset to 0.

## Timing
- Input latency: from a `pwm_in` edge to `rise`/`fall` is `SYNC_STAGES`+1 cycles, plus `FILT_LEN` cycles when the filter is in.
- `meas_valid` is registered: it asserts the cycle after `rise` and stays high for exactly 1 cycle.
- Input limits: both the minimum resolvable high time and the minimum low time are 1 cycle without the filter and `FILT_LEN` cycles with it.
- Throughput: one measurement per input period. There is no handshake or back-pressure; a consumer that misses a strobe loses that sample.

## Configuration
- Macro: `PWM_CAPTURE_FILTER_EN`.
- Defined: `s` changes only after `FILT_LEN` consecutive synchronized samples agree with the new value. Shorter pulses are removed.
- Undefined: `s` is the synchronizer output directly, and `FILT_LEN` is unused.

## Structure
- Shared package `pwm_pkg`:
  - State encoding localparams (IDLE, ARM, RUN).
  - Default constants `PWM_CNT_W`=32 and `PWM_TIMEOUT_DEF`=50_000_000.
- Sub-module `pwm_in_conditioner`: contains the synchronizer and the `PWM_CAPTURE_FILTER_EN` filter, and outputs `s`.
- `pwm_capture` contains the FSM, counter and capture registers.

## Test plan
- Reset with `pwm_in` toggling → all outputs 0 during reset and for the first cycle after release.
- Steady input, P=100, H=30, `enable`=1 → first `meas_valid` on the second rising edge. Every following edge gives `period`=100 and `high_time`=30.
- `TIMEOUT`=1000:
  - Input held low → `timeout`=1 and `level`=0 exactly 1000 cycles after the last rise; the last measurement is retained.
  - Input held high → same timing, with `level`=1.
  - Toggling then resumed → `timeout` clears on the second rising edge, together with a valid measurement.
- `enable` dropped at cycle 50 of a P=100 period, then restored → no strobe for the interrupted period, and the measurement restarts from ARM.
- Filter compiled in, `FILT_LEN`=4, 2-cycle glitch inside the high phase of P=100, H=30 → `high_time`=30 unchanged. Without the filter, the same glitch gives a shortened `high_time`, or an extra rise with a short `period`.
- Period changed from 100 to 250 mid-stream → the next strobe after the first 250-cycle rising edge reports `period`=250.
